// File: rtl/err_watchdog_if.sv
// Signal bundle between a monitored processor/bench and the err_watchdog fault monitor.
// ERR_WDOG_FIRSTCYC_EN adds the fault_cycle snapshot signal.
interface err_watchdog_if #(
    parameter int unsigned NERR  = 4,
    parameter int unsigned CNT_W = 32
);
    logic             retire;
    logic             halt;
    logic [NERR-1:0]  err_in;
    logic             clear;
    logic             err;
    logic [1:0]       err_code;
    logic [NERR-1:0]  err_src;
    logic [1:0]       state;
    logic [CNT_W-1:0] cycle_cnt;
`ifdef ERR_WDOG_FIRSTCYC_EN
    logic [CNT_W-1:0] fault_cycle;

    modport master (
        output retire, halt, err_in, clear,
        input  err, err_code, err_src, state, cycle_cnt, fault_cycle
    );
    modport slave (
        input  retire, halt, err_in, clear,
        output err, err_code, err_src, state, cycle_cnt, fault_cycle
    );
`else
    modport master (
        output retire, halt, err_in, clear,
        input  err, err_code, err_src, state, cycle_cnt
    );
    modport slave (
        input  retire, halt, err_in, clear,
        output err, err_code, err_src, state, cycle_cnt
    );
`endif
endinterface

// File: rtl/err_watchdog.sv
// Run-time fault monitor: flags hangs, reported source errors and retire-after-halt.
// Optional feature macro ERR_WDOG_FIRSTCYC_EN adds a fault_cycle snapshot output.
module err_watchdog #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned HOLDOFF = 2,
    parameter int unsigned NERR    = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic          clk,
    input  logic          rst,
    err_watchdog_if.slave bus
);
    localparam int unsigned IdleW = $clog2(TIMEOUT);
    localparam int unsigned HoldW = $clog2(HOLDOFF + 1);

    localparam logic [1:0] CodeNone    = 2'd0;
    localparam logic [1:0] CodeSrc     = 2'd1;
    localparam logic [1:0] CodeTimeout = 2'd2;
    localparam logic [1:0] CodeHalt    = 2'd3;

    typedef enum logic [1:0] {
        StHold   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2,
        StFault  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [1:0]       code_q, code_d;
    logic [NERR-1:0]  src_q, src_d;
    logic [CNT_W-1:0] cycle_q;
    logic             any_err;

    assign any_err = |bus.err_in;

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        hold_d  = hold_q;
        code_d  = code_q;
        src_d   = src_q;
        unique case (state_q)
            StHold: begin
                if (hold_q == HoldW'(HOLDOFF - 1)) begin
                    state_d = StRun;
                    idle_d  = '0;
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            StRun: begin
                idle_d = bus.retire ? '0 : idle_q + IdleW'(1);
                if (any_err) begin
                    state_d = StFault;
                    code_d  = CodeSrc;
                    src_d   = bus.err_in;
                end else if (!bus.retire && idle_q == IdleW'(TIMEOUT - 1)) begin
                    state_d = StFault;
                    code_d  = CodeTimeout;
                    src_d   = '0;
                end else if (bus.halt) begin
                    state_d = StHalted;
                end
            end
            StHalted: begin
                // idle is frozen here; only errors or a stray retire leave HALTED
                if (any_err) begin
                    state_d = StFault;
                    code_d  = CodeSrc;
                    src_d   = bus.err_in;
                end else if (bus.retire) begin
                    state_d = StFault;
                    code_d  = CodeHalt;
                    src_d   = '0;
                end
            end
            StFault: begin
                // sticky: later faults never overwrite the first code/src
                if (bus.clear && !any_err) begin
                    state_d = StRun;
                    idle_d  = '0;
                    code_d  = CodeNone;
                    src_d   = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StHold;
            idle_q  <= '0;
            hold_q  <= '0;
            code_q  <= CodeNone;
            src_q   <= '0;
            cycle_q <= '0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            hold_q  <= hold_d;
            code_q  <= code_d;
            src_q   <= src_d;
            if (cycle_q != '1) begin
                cycle_q <= cycle_q + CNT_W'(1);
            end
        end
    end

`ifdef ERR_WDOG_FIRSTCYC_EN
    logic [CNT_W-1:0] fault_cycle_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_cycle_q <= '0;
        end else if (state_q != StFault && state_d == StFault) begin
            fault_cycle_q <= cycle_q;
        end
    end

    assign bus.fault_cycle = fault_cycle_q;
`endif

    assign bus.err       = (state_q == StFault);
    assign bus.err_code  = code_q;
    assign bus.err_src   = src_q;
    assign bus.state     = state_q;
    assign bus.cycle_cnt = cycle_q;
endmodule

// File: tb/tb_err_watchdog.sv
// Directed self-checking bench for err_watchdog (TIMEOUT=16, HOLDOFF=2).
module tb_err_watchdog;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    err_watchdog_if #(.NERR(4), .CNT_W(32)) bus ();

    err_watchdog #(
        .TIMEOUT(16),
        .HOLDOFF(2),
        .NERR   (4),
        .CNT_W  (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #3;
        repeat (2) step();
        rst = 1'b1;
    endtask

    initial begin
        bus.retire = 1'b0;
        bus.halt   = 1'b0;
        bus.err_in = 4'b0000;
        bus.clear  = 1'b0;

        // Reset state
        do_reset();
        chk("rst_state", 64'(bus.state), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        chk("rst_code", 64'(bus.err_code), 64'd0);
        chk("rst_src", 64'(bus.err_src), 64'd0);
        chk("rst_cycle", 64'(bus.cycle_cnt), 64'd0);

        // Test 1: retire every 3rd cycle, never a fault
        step();
        chk("t1_hold_edge1", 64'(bus.state), 64'd0);
        step();
        chk("t1_run_edge2", 64'(bus.state), 64'd1);
        for (int i = 0; i < 100; i++) begin
            bus.retire = (i % 3 == 2);
            step();
            chk("t1_no_err", 64'(bus.err), 64'd0);
        end
        bus.retire = 1'b0;
        chk("t1_state_run", 64'(bus.state), 64'd1);

        // Test 2: hang timeout 16 edges after entering RUN
        do_reset();
        repeat (17) step();
        chk("t2_edge17_err", 64'(bus.err), 64'd0);
        step();
        chk("t2_err", 64'(bus.err), 64'd1);
        chk("t2_code", 64'(bus.err_code), 64'd2);
        chk("t2_src", 64'(bus.err_src), 64'd0);
        chk("t2_cycle", 64'(bus.cycle_cnt), 64'd18);
        chk("t2_state", 64'(bus.state), 64'd3);

        // Test 3: one-cycle source error
        do_reset();
        repeat (2) step();
        bus.err_in = 4'b0100;
        step();
        bus.err_in = 4'b0000;
        chk("t3_err", 64'(bus.err), 64'd1);
        chk("t3_code", 64'(bus.err_code), 64'd1);
        chk("t3_src", 64'(bus.err_src), 64'h4);
        repeat (3) step();
        chk("t3_hold_err", 64'(bus.err), 64'd1);
        chk("t3_hold_code", 64'(bus.err_code), 64'd1);
        chk("t3_hold_src", 64'(bus.err_src), 64'h4);

        // Test 4: halt with same-cycle retire, long idle, then retire after halt
        do_reset();
        repeat (2) step();
        bus.halt   = 1'b1;
        bus.retire = 1'b1;
        step();
        bus.halt   = 1'b0;
        bus.retire = 1'b0;
        chk("t4_halted", 64'(bus.state), 64'd2);
        chk("t4_halt_noerr", 64'(bus.err), 64'd0);
        repeat (2000) step();
        chk("t4_idle_noerr", 64'(bus.err), 64'd0);
        chk("t4_still_halted", 64'(bus.state), 64'd2);
        bus.retire = 1'b1;
        step();
        bus.retire = 1'b0;
        chk("t4_err", 64'(bus.err), 64'd1);
        chk("t4_code", 64'(bus.err_code), 64'd3);
        chk("t4_src", 64'(bus.err_src), 64'd0);

        // Test 5: source error beats timeout on the same edge; clear behaviour
        do_reset();
        repeat (17) step();
        chk("t5_pre_err", 64'(bus.err), 64'd0);
        bus.err_in = 4'b0011;
        step();
        chk("t5_code", 64'(bus.err_code), 64'd1);
        chk("t5_src", 64'(bus.err_src), 64'h3);
        bus.clear = 1'b1;
        step();
        chk("t5_clr_blocked_state", 64'(bus.state), 64'd3);
        chk("t5_clr_blocked_code", 64'(bus.err_code), 64'd1);
        chk("t5_clr_blocked_src", 64'(bus.err_src), 64'h3);
        bus.err_in = 4'b0000;
        step();
        bus.clear = 1'b0;
        chk("t5_clr_state", 64'(bus.state), 64'd1);
        chk("t5_clr_err", 64'(bus.err), 64'd0);
        chk("t5_clr_code", 64'(bus.err_code), 64'd0);
        chk("t5_clr_src", 64'(bus.err_src), 64'd0);
        repeat (15) step();
        chk("t5_idle15_noerr", 64'(bus.err), 64'd0);
        step();
        chk("t5_idle16_err", 64'(bus.err), 64'd1);
        chk("t5_idle16_code", 64'(bus.err_code), 64'd2);

        // Test 6: asynchronous reset mid-FAULT, between edges
        rst = 1'b0;
        #1;
        chk("t6_err", 64'(bus.err), 64'd0);
        chk("t6_state", 64'(bus.state), 64'd0);
        chk("t6_code", 64'(bus.err_code), 64'd0);
        chk("t6_cycle", 64'(bus.cycle_cnt), 64'd0);
`ifdef ERR_WDOG_FIRSTCYC_EN
        chk("t6_fault_cycle", 64'(bus.fault_cycle), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
